reset_sequencer: RTL
====================

Name: reset_sequencer

Overview:
- Parametrised, multi-source, multi-output reset generator. It replaces the single-counter reset stretcher in the board top that combined the upload-done and button edges.
- Synchronises N reset request sources and qualifies each one as a falling-edge or high-level trigger with a per-source enable.
- Holds all reset outputs for a programmable stretch, then releases them in a staggered order, for example memory/video first and CPU last.
- Records which sources caused a reset, for debug display on the OSD or LED.

Parameters:
- NUM_SRC, 4: number of reset request inputs (1..16).
- NUM_OUT, 2: number of reset outputs / release stages (1..8).
- STRETCH, 16: cycles all outputs stay high after the last trigger (>=1).
- STAGGER, 8: cycles between consecutive output releases (0 = simultaneous release).
- SYNC_STAGES, 2: synchroniser flops per source (>=1).

Ports:
- clk  in  1  single clock for the whole block (cpu_clk domain in the board top).
- res  in  1  synchronous, active-high reset.
- src  in  NUM_SRC  raw reset requests, may be asynchronous to clk.
- src_en  in  NUM_SRC  per-source enable; 0 = source ignored.
- src_level  in  NUM_SRC  per-source mode; 1 = high-level trigger, 0 = falling-edge trigger.
- cause_clr  in  1  one-cycle pulse that clears cause and por_flag.
- rst_out  out  NUM_OUT  active-high reset outputs; bit 0 is released first.
- busy  out  1  high while any rst_out bit is high.
- cause  out  NUM_SRC  sticky record of sources that triggered.
- por_flag  out  1  sticky; set by res.

Behaviour:
- Reset values while res=1:
  - rst_out = all ones, busy = 1, state = ASSERT, counter = 0.
  - cause = 0, por_flag = 1.
  - Synchroniser and previous-sample flops = 0, so no false edge occurs after reset.
  - Every cycle with res=1 counts as a trigger cycle.
- Source detection:
  - Each src bit passes through SYNC_STAGES flops; s = last stage, p = s delayed one cycle.
  - trig[i] = src_en[i] & (src_level[i] ? s : (p & ~s)).
  - any_trig = |trig.
- Latency: a src change sampled at edge k raises rst_out at edge k+SYNC_STAGES.
- States: IDLE, ASSERT, RELEASE.
- IDLE:
  - rst_out = 0, busy = 0.
  - any_trig -> ASSERT with rst_out = all ones and counter = 0.
- ASSERT:
  - rst_out = all ones.
  - any_trig restarts counter at 0; otherwise the counter increments.
  - When counter = STRETCH-1 and there is no trig, go to RELEASE with counter = 0.
  - rst_out[0] falls on that same edge, so the outputs stay high exactly STRETCH cycles after the last trigger cycle.
  - A level-mode source held high keeps the block in ASSERT indefinitely.
- RELEASE:
  - rst_out[j] falls at j*STAGGER edges after rst_out[0] fell.
  - When rst_out[NUM_OUT-1] falls, go to IDLE on the same edge.
  - With STAGGER=0 or NUM_OUT=1, RELEASE lasts zero cycles: all outputs fall together and the state goes straight to IDLE.
  - any_trig in RELEASE -> ASSERT with all outputs high again and counter = 0; the full sequence repeats.
- Release order: outputs are always released in index order; a lower index is never high while a higher index is low.
- busy = |rst_out, registered with it (no extra latency).
- cause register:
  - cause[i] is set on any cycle with trig[i].
  - cause_clr clears cause and por_flag.
  - Simultaneous set and clear: the set wins for that bit; res wins over everything.
- Counter: an unsigned counter of width clog2(max(STRETCH, STAGGER*(NUM_OUT-1))+1). It saturates, never wraps, and is only compared against constants.
- Gating sources: src_en and src_level are sampled unsynchronised; they must be quasi-static. Disabling a source while it is asserting is allowed; the stretch then proceeds from the last trigger.

Decomposition:
- Package reset_seq_pkg holds:
  - the state encodings as localparams (IDLE=2'd0, ASSERT=2'd1, RELEASE=2'd2);
  - a clog2-based counter-width function.
- Sub-module reset_src_detect, one per source via generate:
  - contains the synchroniser, the previous-sample flop, and the edge/level qualification;
  - outputs a single trig bit;
  - parameterised by SYNC_STAGES.
- The top of the block holds the FSM, the counter, and the cause/por registers.

Test Plan (defaults NUM_SRC=4, NUM_OUT=2, STRETCH=16, STAGGER=8, SYNC_STAGES=2):
1. res high for 3 cycles, then low, with src idle:
   - rst_out = 2'b11 until 16 edges after the last res cycle, then 2'b10, and 8 edges later 2'b00;
   - busy falls together with rst_out[1]; por_flag = 1; cause = 0.
2. Edge trigger: src[1] goes 1 -> 0 with src_en = 4'b1111 and src_level = 0:
   - rst_out = 2'b11 two edges after the edge that samples src[1] = 0;
   - cause = 4'b0010.
3. Retrigger in ASSERT: a second src[1] falling edge arrives at counter = 10:
   - counter restarts; rst_out[0] falls 16 edges after the second trigger;
   - total assert time is 26+ cycles.
4. Level hold: src_level[2] = 1 and src[2] held high for 40 cycles:
   - rst_out stays 2'b11 throughout, then falls 16 edges after s drops;
   - cause[2] = 1.
5. Masked source: src[3] toggles 5 times with src_en[3] = 0:
   - rst_out stays 0 and cause is unchanged.
6. Trigger in RELEASE plus clear collision:
   - src[0] falls 4 cycles after rst_out[0] fell (rst_out = 2'b10), with cause_clr pulsed in the same cycle as trig[0];
   - rst_out returns to 2'b11 and the full 16+8 sequence repeats;
   - cause = 4'b0001 and por_flag = 0.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM encoding and counter sizing.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Counter must reach both the stretch length and the last release offset.
  function automatic int cnt_width(input int stretch, input int stagger, input int num_out);
    int span;
    span = stagger * (num_out - 1);
    if (stretch > span) span = stretch;
    return $clog2(span + 1);
  endfunction

endpackage

// File: rtl/reset_src_detect.sv
// One reset request source: synchroniser, previous-sample flop and edge/level qualification.
module reset_src_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic res,
  input  logic src,
  input  logic en,
  input  logic level,
  output logic trig
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   prev;

  assign s = sync[SYNC_STAGES-1];

  // Clearing both sync and prev on reset means a source idling high produces no falling edge.
  always_ff @(posedge clk) begin
    if (res) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync[0] <= src;
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      prev <= s;
    end
  end

  assign trig = en & (level ? s : (prev & ~s));

endmodule

// File: rtl/reset_sequencer.sv
// Multi-source reset generator: stretches all outputs after the last trigger, then releases them in index order.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int NUM_OUT     = 2,
  parameter int STRETCH     = 16,
  parameter int STAGGER     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               res,
  input  logic [NUM_SRC-1:0] src,
  input  logic [NUM_SRC-1:0] src_en,
  input  logic [NUM_SRC-1:0] src_level,
  input  logic               cause_clr,
  output logic [NUM_OUT-1:0] rst_out,
  output logic               busy,
  output logic [NUM_SRC-1:0] cause,
  output logic               por_flag
);

  localparam int            CW          = cnt_width(STRETCH, STAGGER, NUM_OUT);
  localparam logic [CW-1:0] CNT_MAX     = '1;
  localparam logic [CW-1:0] STRETCH_END = CW'(STRETCH - 1);
  localparam logic [CW-1:0] REL_END     = CW'(STAGGER * (NUM_OUT - 1));

  logic [NUM_SRC-1:0] trig;
  logic               any_trig;

  state_t             state, state_next;
  logic [CW-1:0]      cnt, cnt_next, cnt_inc;
  logic [NUM_OUT-1:0] rst_next;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    reset_src_detect #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_detect (
      .clk  (clk),
      .res  (res),
      .src  (src[i]),
      .en   (src_en[i]),
      .level(src_level[i]),
      .trig (trig[i])
    );
  end

  assign any_trig = |trig;

  // Outputs still held when the release counter reads c: bit j drops once c reaches j*STAGGER.
  function automatic logic [NUM_OUT-1:0] held_mask(input logic [CW-1:0] c);
    logic [NUM_OUT-1:0] m;
    for (int j = 0; j < NUM_OUT; j++) m[j] = (int'(c) < j * STAGGER);
    return m;
  endfunction

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    rst_next   = rst_out;
    cnt_inc    = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
    case (state)
      IDLE: begin
        rst_next = '0;
        if (any_trig) begin
          state_next = ASSERT;
          cnt_next   = '0;
          rst_next   = '1;
        end
      end
      ASSERT: begin
        rst_next = '1;
        if (any_trig) begin
          cnt_next = '0;
        end else if (cnt == STRETCH_END) begin
          cnt_next   = '0;
          rst_next   = held_mask('0);
          // A zero-length release span skips RELEASE and drops everything at once.
          state_next = (REL_END == '0) ? IDLE : RELEASE;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      RELEASE: begin
        if (any_trig) begin
          state_next = ASSERT;
          cnt_next   = '0;
          rst_next   = '1;
        end else begin
          cnt_next = cnt_inc;
          rst_next = held_mask(cnt_inc);
          if (cnt_inc == REL_END) state_next = IDLE;
        end
      end
      default: begin
        state_next = ASSERT;
        cnt_next   = '0;
        rst_next   = '1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state    <= ASSERT;
      cnt      <= '0;
      rst_out  <= '1;
      busy     <= 1'b1;
      cause    <= '0;
      por_flag <= 1'b1;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      rst_out  <= rst_next;
      busy     <= |rst_next;
      // A new trigger in the clearing cycle still lands in cause.
      cause    <= (cause_clr ? '0 : cause) | trig;
      if (cause_clr) por_flag <= 1'b0;
    end
  end

endmodule
